uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
//  - Transmit half of the FPGC4 UART; drives the top-level uart_out pin (8N1, LSB first).
//  - Complements the existing receive path (uart_in / uart_rx_interrupt) inside MemoryUnit.
//  - MemoryUnit pushes bytes on a CPU store to the UART TX address; a FIFO decouples CPU writes from line timing.
//  - tx_done_interrupt is intended for a spare CPU ext_int line.
// PARAMETERS
//  CLK_HZ      50000000  system clock frequency (Hz)
//  BAUD        115200    line rate; DIV = (CLK_HZ + BAUD/2) / BAUD cycles per bit (434 at defaults)
//  FIFO_DEPTH  16        TX FIFO entries; power of two, >= 2
// PORTS
//  clk                in   1  system clock, 50 MHz
//  reset              in   1  asynchronous, active-high
//  tx_data            in   8  byte to queue
//  tx_write           in   1  one-cycle push strobe from MemoryUnit
//  tx_full            out  1  FIFO holds FIFO_DEPTH bytes
//  tx_empty           out  1  FIFO holds 0 bytes (a frame may still be on the line)
//  tx_busy            out  1  FSM not IDLE
//  tx_overflow        out  1  sticky: a push was dropped
//  tx_clr_overflow    in   1  clears tx_overflow
//  tx_done_interrupt  out  1  one-cycle pulse at the end of each stop bit
//  uart_out           out  1  serial line, idle high, registered
// BEHAVIOUR
//  - Reset (async): uart_out=1, FIFO empty (tx_empty=1, tx_full=0), tx_busy=0, tx_overflow=0, tx_done_interrupt=0, FSM=IDLE, bit counter=0.
//  - FSM: IDLE -> START -> DATA(x8) -> [PARITY] -> STOP -> IDLE, or STOP -> START when the FIFO is non-empty.
//  - IDLE: at the first edge where the FIFO is non-empty, pop the head into the shift register and enter START; uart_out=0 from that edge.
//  - Latency: push at edge N into an empty FIFO while IDLE -> uart_out falls at edge N+1.
//  - Each bit holds for exactly DIV clocks. The baud counter reloads on every state or bit change.
//  - No free-running phase: each frame is aligned to its own start edge.
//  - DATA: bit 0 first; shift right on each bit boundary.
//  - STOP: uart_out=1 for DIV clocks. tx_done_interrupt is high on the final STOP cycle.
//  - Back-to-back frames: with the FIFO non-empty at the end of STOP, the next START begins on the next cycle, with no idle gap.
//  - Frame length: 10*DIV clocks (11*DIV clocks with parity).
//  - Push accepted iff !tx_full, or a pop occurs on the same edge.
//  - A push and a pop on the same edge leave the count unchanged and the data ordered correctly.
//  - Rejected push: tx_overflow is set and the FIFO is unchanged.
//  - tx_clr_overflow and a rejected push on the same edge: set wins.
//  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
//  - Reset mid-frame: line returns high immediately. The partial frame is abandoned and queued bytes are discarded.
//  - tx_data is ignored when tx_write=0.
// CONFIGURATION
//  - UART_TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) is sent in state PARITY between DATA and STOP.
//  - UART_TX_PARITY_EN undefined: state PARITY and its logic are not compiled. Format is 8N1.
// STRUCTURE
//  - Shared package/include uart_pkg holds:
//    - FSM state encodings (IDLE, START, DATA, PARITY, STOP), shared with the RX side;
//    - the baud divider constant function;
//    - data-width constant 8.
//  - Sub-module tx_byte_fifo: synchronous FIFO with push/pop/full/empty and an async-reset pointer.
//  - Shift register, baud counter and FSM stay in uart_tx_buffered.
// TESTING  (bench parameters: CLK_HZ=1000, BAUD=100 -> DIV=10)
//  1. Reset released, no pushes for 200 clocks -> uart_out=1, tx_empty=1, tx_busy=0 throughout.
//  2. Push 0xA5 at edge N -> uart_out falls at N+1.
//     Bits sampled mid-bit read 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each 10 clocks.
//     Single tx_done_interrupt pulse at N+100.
//  3. Push 0x00 then 0xFF on consecutive cycles -> two frames with no idle gap between them.
//     Exactly 2 done pulses, 100 clocks apart.
//  4. Push 17 bytes 0x00..0x10 on consecutive cycles:
//     - first byte pops at N+1, so 0x00..0x10 are all accepted and tx_full=1;
//     - one further push (0x11) while full -> tx_overflow=1, 0x11 never transmitted;
//     - pulse tx_clr_overflow -> tx_overflow=0;
//     - all 17 accepted bytes are received in order.
//  5. Push 0x3C, assert reset for 1 clock at clock 35 of the frame -> uart_out=1 within the same cycle.
//     tx_empty=1, tx_busy=0; a subsequent push of 0x3C transmits cleanly.
//  6. UART_TX_PARITY_EN defined, push 0x07 -> frame is 110 clocks with parity bit 1.
//     Push 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (common to the RX and TX sides),
// the data width, and the baud divider constant function.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Synchronous byte FIFO for the UART transmitter. A push is accepted when there
// is room or when a pop happens on the same edge.
module tx_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty,
    output logic         accept
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign accept  = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            case ({accept, do_pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter (8N1, LSB first) fed from a byte FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_write,
    output logic              tx_full,
    output logic              tx_empty,
    output logic              tx_busy,
    output logic              tx_overflow,
    input  logic              tx_clr_overflow,
    output logic              tx_done_interrupt,
    output logic              uart_out
);

    localparam int DIV   = baud_div(CLK_HZ, BAUD);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    uart_state_t       state_q, state_next;
    logic [CNT_W-1:0]  cnt_q, cnt_next;
    logic [BIT_W-1:0]  bit_q, bit_next;
    logic [DATA_W-1:0] shift_q, shift_next;
    logic              line_q, line_next;
    logic              pop_req;
    logic              baud_end;
    logic              push_accept;
    logic [DATA_W-1:0] fifo_rd_data;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_next;
`endif

    tx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (tx_write),
        .pop     (pop_req),
        .wr_data (tx_data),
        .rd_data (fifo_rd_data),
        .full    (tx_full),
        .empty   (tx_empty),
        .accept  (push_accept)
    );

    assign baud_end          = (cnt_q == CNT_LAST);
    assign tx_busy           = (state_q != ST_IDLE);
    assign tx_done_interrupt = (state_q == ST_STOP) && baud_end;
    assign uart_out          = line_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            line_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_next;
            cnt_q    <= cnt_next;
            bit_q    <= bit_next;
            shift_q  <= shift_next;
            line_q   <= line_next;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_q;
        cnt_next    = cnt_q + CNT_W'(1);
        bit_next    = bit_q;
        shift_next  = shift_q;
        line_next   = line_q;
        pop_req     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_next = '0;
                if (!tx_empty) begin
                    pop_req    = 1'b1;
                    shift_next = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^fifo_rd_data;
`endif
                    state_next = ST_START;
                    line_next  = 1'b0;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = ST_DATA;
                    line_next  = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    cnt_next   = '0;
                    shift_next = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
                        line_next  = parity_q;
`else
                        state_next = ST_STOP;
                        line_next  = 1'b1;
`endif
                    end else begin
                        bit_next  = bit_q + BIT_W'(1);
                        line_next = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_end) begin
                    cnt_next   = '0;
                    state_next = ST_STOP;
                    line_next  = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_end) begin
                    cnt_next = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!tx_empty) begin
                        pop_req    = 1'b1;
                        shift_next = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                        parity_next = ^fifo_rd_data;
`endif
                        state_next = ST_START;
                        line_next  = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                        line_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                line_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_overflow <= 1'b0;
        end else if (tx_write && !push_accept) begin
            tx_overflow <= 1'b1;
        end else if (tx_clr_overflow) begin
            tx_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered: serial receiver model feeding a frame scoreboard,
// plus directed latency, back-to-back, overflow and mid-frame reset checks.
module tb_uart_tx_buffered;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DIV    = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_W = 11;
`else
    localparam int FRAME_W = 10;
`endif
    localparam int FRAME_CLKS = FRAME_W * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_write = 1'b0;
    logic       tx_clr_overflow = 1'b0;
    logic       tx_full, tx_empty, tx_busy, tx_overflow, tx_done_interrupt, uart_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rst_cnt  = 0;
    int last_push_cyc = 0;
    bit rx_busy  = 1'b0;

    logic [FRAME_W-1:0] exp_q[$];
    int start_q[$];
    int done_q[$];

    uart_tx_buffered #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .tx_data           (tx_data),
        .tx_write          (tx_write),
        .tx_full           (tx_full),
        .tx_empty          (tx_empty),
        .tx_busy           (tx_busy),
        .tx_overflow       (tx_overflow),
        .tx_clr_overflow   (tx_clr_overflow),
        .tx_done_interrupt (tx_done_interrupt),
        .uart_out          (uart_out)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge reset) rst_cnt++;
    always @(negedge clk) if (tx_done_interrupt) done_q.push_back(cyc);

    // ---------------- helpers ----------------
    function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive a one-cycle push; returns #1 after the sampling edge with the edge index recorded.
    task automatic push_byte(input logic [7:0] b, input bit expect_tx);
        tx_data  = b;
        tx_write = 1'b1;
        @(posedge clk);
        #1;
        last_push_cyc = cyc;
        tx_write = 1'b0;
        tx_data  = 8'($urandom_range(0, 255));
        if (expect_tx) exp_q.push_back(make_frame(b));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || tx_busy || rx_busy) && n < budget);
        check("wait_idle_timeout", (n >= budget), 0);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- receiver / scoreboard monitor ----------------
    initial begin
        logic [FRAME_W-1:0] frame;
        logic [FRAME_W-1:0] exp;
        int s_cyc;
        int r0;
        forever begin
            @(negedge clk);
            if (reset || uart_out !== 1'b0) continue;
            rx_busy = 1'b1;
            s_cyc = cyc;
            r0 = rst_cnt;
            repeat (DIV / 2 - 1) @(negedge clk);
            frame[0] = uart_out;
            for (int i = 1; i < FRAME_W; i++) begin
                repeat (DIV) @(negedge clk);
                frame[i] = uart_out;
            end
            rx_busy = 1'b0;
            if (r0 == rst_cnt) begin
                start_q.push_back(s_cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got 0x%0h, expected no frame", frame);
                end else begin
                    exp = exp_q.pop_front();
                    check("frame", 32'(frame), 32'(exp));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int bad;
        int n0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_uart_out", uart_out, 1);
        check("reset_tx_empty", tx_empty, 1);
        check("reset_tx_full", tx_full, 0);
        check("reset_tx_busy", tx_busy, 0);
        check("reset_tx_overflow", tx_overflow, 0);
        check("reset_done", tx_done_interrupt, 0);
        reset = 1'b0;

        // 1. Idle line for 200 clocks
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (uart_out !== 1'b1 || tx_empty !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("idle_200_violations", bad, 0);
        @(posedge clk);
        #1;

        // 2. Single 0xA5 frame: latency, bit pattern, done pulse
        start_q.delete();
        done_q.delete();
        push_byte(8'hA5, 1'b1);
        n0 = last_push_cyc;
        wait_idle(400);
        check("a5_start_count", start_q.size(), 1);
        if (start_q.size() > 0) check("a5_start_latency", start_q[0], n0 + 1);
        check("a5_done_count", done_q.size(), 1);
        if (done_q.size() > 0) check("a5_done_cycle", done_q[0], n0 + FRAME_CLKS);

        // 3. Back-to-back 0x00, 0xFF
        start_q.delete();
        done_q.delete();
        @(posedge clk);
        #1;
        push_byte(8'h00, 1'b1);
        n0 = last_push_cyc;
        push_byte(8'hFF, 1'b1);
        wait_idle(600);
        check("b2b_done_count", done_q.size(), 2);
        if (done_q.size() == 2) check("b2b_done_spacing", done_q[1] - done_q[0], FRAME_CLKS);
        check("b2b_start_count", start_q.size(), 2);
        if (start_q.size() == 2) begin
            check("b2b_first_start", start_q[0], n0 + 1);
            check("b2b_no_gap", start_q[1] - start_q[0], FRAME_CLKS);
        end

        // 4. Fill FIFO, overflow, clear, drain in order
        start_q.delete();
        done_q.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i <= 16; i++) push_byte(8'(i), 1'b1);
        check("fill_tx_full", tx_full, 1);
        check("fill_no_overflow", tx_overflow, 0);
        push_byte(8'h11, 1'b0);
        check("ovf_set", tx_overflow, 1);
        check("ovf_still_full", tx_full, 1);
        tx_clr_overflow = 1'b1;
        @(posedge clk);
        #1;
        tx_clr_overflow = 1'b0;
        check("ovf_cleared", tx_overflow, 0);
        tx_clr_overflow = 1'b1;
        push_byte(8'h12, 1'b0);
        tx_clr_overflow = 1'b0;
        check("ovf_set_wins_over_clr", tx_overflow, 1);
        tx_clr_overflow = 1'b1;
        @(posedge clk);
        #1;
        tx_clr_overflow = 1'b0;
        check("ovf_cleared_again", tx_overflow, 0);
        wait_idle(17 * FRAME_CLKS + 400);
        check("fill_done_count", done_q.size(), 17);
        check("fill_tx_empty", tx_empty, 1);

        // 5. Reset mid-frame, then a clean retransmission
        start_q.delete();
        done_q.delete();
        @(posedge clk);
        #1;
        push_byte(8'h3C, 1'b0);
        repeat (34) @(posedge clk);
        #1;
        check("midframe_busy_before_reset", tx_busy, 1);
        reset = 1'b1;
        #1;
        check("midframe_uart_out", uart_out, 1);
        check("midframe_tx_empty", tx_empty, 1);
        check("midframe_tx_busy", tx_busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_idle(400);
        check("midframe_no_done", done_q.size(), 0);
        @(posedge clk);
        #1;
        push_byte(8'h3C, 1'b1);
        wait_idle(400);
        check("after_reset_done_count", done_q.size(), 1);

`ifdef UART_TX_PARITY_EN
        // 6. Parity frames: 0x07 -> parity 1, 0x03 -> parity 0
        done_q.delete();
        @(posedge clk);
        #1;
        push_byte(8'h07, 1'b1);
        push_byte(8'h03, 1'b1);
        wait_idle(600);
        check("parity_done_count", done_q.size(), 2);
        if (done_q.size() == 2) check("parity_frame_len", done_q[1] - done_q[0], 110);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #(900000);
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
